// File: rtl/ack_packetizer.sv
// Builds one fixed-length 60-byte acknowledgement frame per accepted request and streams it
// out as fifteen 32-bit AXI-Stream beats, counting completed frames since reset.
module ack_packetizer #(
  parameter int unsigned XLEN       = 64,
  parameter logic [47:0] DEST_MAC   = 48'h8F54_0000_1654,
  parameter logic [47:0] SRC_MAC    = 48'h4502_1111_6843,
  parameter logic [15:0] ETHER_TYPE = 16'h005C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid,
  input  logic [XLEN-1:0] Minstr,
  input  logic [31:0]     InterPacketDelay,
  output logic            Ready,
  output logic [31:0]     TxAxiTdata,
  output logic [3:0]      TxAxiTstrb,
  output logic            TxAxiTlast,
  output logic            TxAxiTvalid,
  input  logic            TxAxiTready,
  output logic [31:0]     FrameCount
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  localparam logic [3:0] LastBeat = 4'd14;

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [63:0] minstr_q, minstr_d;
  logic [31:0] delay_q, delay_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic        ready_q, ready_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [31:0] tdata_q, tdata_d;

  function automatic logic [31:0] beat_word(input logic [3:0] beat, input logic [63:0] m,
                                            input logic [31:0] d);
    logic [31:0] w;
    w = 32'h0;
    case (beat)
      4'd0:    w = DEST_MAC[31:0];
      4'd1:    w = {SRC_MAC[15:0], DEST_MAC[47:32]};
      4'd2:    w = SRC_MAC[47:16];
      4'd3:    w = {m[15:0], ETHER_TYPE};
      4'd4:    w = m[47:16];
      4'd5:    w = {d[15:0], m[63:48]};
      4'd6:    w = {16'h0, d[31:16]};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    minstr_d      = minstr_q;
    delay_d       = delay_q;
    frame_count_d = frame_count_q;
    case (state_q)
      StIdle: begin
        if (Valid) begin
          state_d  = StSend;
          beat_d   = 4'd0;
          minstr_d = 64'(Minstr);
          delay_d  = InterPacketDelay;
        end
      end
      StSend: begin
        if (beat_q > LastBeat) begin
          state_d = StIdle;
          beat_d  = 4'd0;
        end else if (TxAxiTready) begin
          if (beat_q == LastBeat) begin
            state_d       = StDone;
            beat_d        = 4'd0;
            frame_count_d = frame_count_q + 32'd1;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        beat_d  = 4'd0;
      end
      default: begin
        state_d = StIdle;
        beat_d  = 4'd0;
      end
    endcase
    // Outputs are registered, so they are derived from the next state.
    ready_d  = (state_d == StIdle);
    tvalid_d = (state_d == StSend);
    tlast_d  = tvalid_d && (beat_d == LastBeat);
    tdata_d  = beat_word(beat_d, minstr_d, delay_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      beat_q        <= 4'd0;
      minstr_q      <= 64'h0;
      delay_q       <= 32'h0;
      frame_count_q <= 32'h0;
      ready_q       <= 1'b1;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= 32'h0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      minstr_q      <= minstr_d;
      delay_q       <= delay_d;
      frame_count_q <= frame_count_d;
      ready_q       <= ready_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
    end
  end

  assign Ready       = ready_q;
  assign TxAxiTvalid = tvalid_q;
  assign TxAxiTlast  = tlast_q;
  assign TxAxiTdata  = tdata_q;
  assign TxAxiTstrb  = tvalid_q ? 4'hF : 4'h0;
  assign FrameCount  = frame_count_q;

endmodule

// File: tb/tb_ack_packetizer.sv
// Bench for ack_packetizer: a frame-level model checked every cycle, plus directed frames with
// hand-computed beat values, backpressure, back-to-back requests and mid-frame reset.
module tb_ack_packetizer;

  localparam logic [47:0] DestMac   = 48'h8F54_0000_1654;
  localparam logic [47:0] SrcMac    = 48'h4502_1111_6843;
  localparam logic [15:0] EtherType = 16'h005C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Valid = 1'b0;
  logic [63:0] Minstr = 64'h0;
  logic [31:0] InterPacketDelay = 32'h0;
  logic        TxAxiTready = 1'b0;
  logic        Ready;
  logic [31:0] TxAxiTdata;
  logic [3:0]  TxAxiTstrb;
  logic        TxAxiTlast;
  logic        TxAxiTvalid;
  logic [31:0] FrameCount;

  ack_packetizer #(.XLEN(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .Valid            (Valid),
    .Minstr           (Minstr),
    .InterPacketDelay (InterPacketDelay),
    .Ready            (Ready),
    .TxAxiTdata       (TxAxiTdata),
    .TxAxiTstrb       (TxAxiTstrb),
    .TxAxiTlast       (TxAxiTlast),
    .TxAxiTvalid      (TxAxiTvalid),
    .TxAxiTready      (TxAxiTready),
    .FrameCount       (FrameCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as a little-endian stream of fields; beat k is bits [32k +: 32].
  function automatic logic [479:0] build(input logic [63:0] m, input logic [31:0] d);
    return {272'b0, d, m, EtherType, SrcMac, DestMac};
  endfunction

  // Model: mode 0 = waiting for request, 1 = streaming, 2 = mandatory gap cycle.
  bit           known = 1'b0;
  int           m_mode = 0;
  int           m_idx = 0;
  logic [31:0]  m_count = 32'h0;
  logic [479:0] m_stream = '0;
  logic [31:0]  got_q[$];

  always @(negedge clk) begin
    if (known) begin
      chk("ready", 64'(Ready), 64'(m_mode == 0));
      chk("tvalid", 64'(TxAxiTvalid), 64'(m_mode == 1));
      chk("tstrb", 64'(TxAxiTstrb), (m_mode == 1) ? 64'hF : 64'h0);
      chk("tlast", 64'(TxAxiTlast), 64'(m_mode == 1 && m_idx == 14));
      if (m_mode == 1) chk("tdata", 64'(TxAxiTdata), 64'(m_stream[32*m_idx +: 32]));
      chk("framecount", 64'(FrameCount), 64'(m_count));
      if (m_mode == 1 && TxAxiTready) got_q.push_back(TxAxiTdata);
    end
    if (!reset) begin
      known   = 1'b1;
      m_mode  = 0;
      m_idx   = 0;
      m_count = 32'h0;
    end else if (known) begin
      case (m_mode)
        0: if (Valid) begin
          m_mode   = 1;
          m_idx    = 0;
          m_stream = build(Minstr, InterPacketDelay);
        end
        1: if (TxAxiTready) begin
          if (m_idx == 14) begin
            m_mode  = 2;
            m_count = m_count + 32'd1;
          end else begin
            m_idx = m_idx + 1;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] m, input logic [31:0] d);
    Minstr = m;
    InterPacketDelay = d;
    Valid = 1'b1;
    cyc();
    Valid = 1'b0;
    // Scramble inputs so a frame built from live inputs would differ.
    Minstr = ~m;
    InterPacketDelay = ~d;
  endtask

  task automatic wait_count(input logic [31:0] target, input int budget);
    int n = 0;
    while (FrameCount !== target && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_frame_done", 64'(FrameCount), 64'(target));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (Ready !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_ready", 64'(Ready), 64'h1);
  endtask

  logic [31:0] ref_a[15];
  logic [3:0]  pat = 4'b1001;
  logic [31:0] base;

  initial begin
    repeat (3) cyc();
    chk("rst_ready", 64'(Ready), 64'h1);
    chk("rst_tvalid", 64'(TxAxiTvalid), 64'h0);
    chk("rst_tlast", 64'(TxAxiTlast), 64'h0);
    chk("rst_tstrb", 64'(TxAxiTstrb), 64'h0);
    chk("rst_count", 64'(FrameCount), 64'h0);
    reset = 1'b1;
    TxAxiTready = 1'b1;
    cyc();

    // Frame A, no backpressure.
    got_q.delete();
    send(64'h0123_4567_89AB_CDEF, 32'h0000_1234);
    wait_count(32'd1, 100);
    chk("a_beats", 64'(got_q.size()), 64'd15);
    if (got_q.size() == 15) begin
      chk("a_b0", 64'(got_q[0]), 64'h0000_1654);
      chk("a_b1", 64'(got_q[1]), 64'h6843_8F54);
      chk("a_b2", 64'(got_q[2]), 64'h4502_1111);
      chk("a_b3", 64'(got_q[3]), 64'hCDEF_005C);
      chk("a_b4", 64'(got_q[4]), 64'h4567_89AB);
      chk("a_b5", 64'(got_q[5]), 64'h1234_0123);
      chk("a_b6", 64'(got_q[6]), 64'h0000_0000);
      chk("a_b14", 64'(got_q[14]), 64'h0000_0000);
      chk("loop_minstr", {got_q[5][15:0], got_q[4], got_q[3][31:16]}, 64'h0123_4567_89AB_CDEF);
      chk("loop_delay", 64'({got_q[6][15:0], got_q[5][31:16]}), 64'h0000_1234);
      for (int i = 0; i < 15; i++) ref_a[i] = got_q[i];
    end else begin
      for (int i = 0; i < 15; i++) ref_a[i] = 32'h0;
    end

    // Same frame under 1,0,0,1 backpressure.
    wait_idle(10);
    got_q.delete();
    Minstr = 64'h0123_4567_89AB_CDEF;
    InterPacketDelay = 32'h0000_1234;
    for (int i = 0; i < 80; i++) begin
      TxAxiTready = pat[i % 4];
      Valid = (i == 0);
      cyc();
    end
    Valid = 1'b0;
    TxAxiTready = 1'b1;
    chk("bp_beats", 64'(got_q.size()), 64'd15);
    if (got_q.size() == 15)
      for (int i = 0; i < 15; i++) chk("bp_word", 64'(got_q[i]), 64'(ref_a[i]));
    chk("bp_count", 64'(FrameCount), 64'd2);

    // 32-bit style count value with upper half zero.
    wait_idle(10);
    got_q.delete();
    send(64'h0000_0000_DEAD_BEEF, 32'hFFFF_0001);
    wait_count(32'd3, 100);
    if (got_q.size() == 15) begin
      chk("c_b3", 64'(got_q[3]), 64'hBEEF_005C);
      chk("c_b4", 64'(got_q[4]), 64'h0000_DEAD);
      chk("c_b5", 64'(got_q[5]), 64'h0001_0000);
      chk("c_b6", 64'(got_q[6]), 64'h0000_FFFF);
    end else begin
      chk("c_beats", 64'(got_q.size()), 64'd15);
    end

    // Valid held high: one frame every 17 cycles.
    wait_idle(10);
    base = FrameCount;
    Minstr = 64'h1111_2222_3333_4444;
    InterPacketDelay = 32'h5555_6666;
    Valid = 1'b1;
    repeat (51) cyc();
    Valid = 1'b0;
    chk("b2b_frames", 64'(FrameCount - base), 64'd3);
    chk("b2b_ready", 64'(Ready), 64'h1);

    // Valid pulses mid-frame are dropped.
    base = FrameCount;
    send(64'hAAAA_BBBB_CCCC_DDDD, 32'h0BAD_F00D);
    repeat (4) cyc();
    Valid = 1'b1;
    repeat (3) cyc();
    Valid = 1'b0;
    repeat (30) cyc();
    chk("pulse_frames", 64'(FrameCount - base), 64'd1);

    // Reset while beat 7 is on the bus.
    wait_idle(10);
    got_q.delete();
    send(64'h0123_4567_89AB_CDEF, 32'h0000_1234);
    for (int n = 0; n < 40 && got_q.size() < 7; n++) cyc();
    chk("mid_beat7", 64'(got_q.size()), 64'd7);
    reset = 1'b0;
    cyc();
    chk("mid_tvalid", 64'(TxAxiTvalid), 64'h0);
    chk("mid_tlast", 64'(TxAxiTlast), 64'h0);
    chk("mid_count", 64'(FrameCount), 64'h0);
    reset = 1'b1;
    cyc();
    chk("mid_ready", 64'(Ready), 64'h1);
    got_q.delete();
    send(64'h0123_4567_89AB_CDEF, 32'h0000_1234);
    wait_count(32'd1, 100);
    chk("post_beats", 64'(got_q.size()), 64'd15);
    if (got_q.size() == 15)
      for (int i = 0; i < 15; i++) chk("post_word", 64'(got_q[i]), 64'(ref_a[i]));
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
